bake_countdown_timer: RTL and testbench

- User-facing bake timer for the oven controller, working opposite to the elapsed-time display.
- Debounces the active-low push buttons and lets the user set a bake duration in minutes.
- Waits for the temperature loop to report setpoint reached, then counts down mm:ss in BCD once per second.
- Raises an alarm at 00:00. The BCD digit outputs feed the existing seven-segment decoders directly.

---
 rtl/oven_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 34 +++
 rtl/bake_countdown_timer.sv | 109 ++++++++++
 tb/tb_bake_countdown_timer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/oven_pkg.sv
// oven_pkg: shared state encoding, BCD constants and digit helpers for the bake timer
package oven_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET     = 3'd1,
    PREHEAT = 3'd2,
    BAKE    = 3'd3,
    DONE    = 3'd4
  } state_t;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX_U = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MAX_T = 4'd5;
  localparam logic [7:0] PRESET_MIN = 8'h01;
  localparam logic [7:0] PRESET_MAX = 8'h99;
  typedef struct packed {
    logic [BCD_W-1:0] m1;
    logic [BCD_W-1:0] m0;
    logic [BCD_W-1:0] s1;
    logic [BCD_W-1:0] s0;
  } digits_t;
  // Expand a 2-digit BCD minute preset into mm:00
  function automatic digits_t show_min(input logic [7:0] p);
    return '{m1: p[7:4], m0: p[3:0], s1: '0, s0: '0};
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes an active-low button and emits one pulse per accepted press
module btn_debounce #(
  parameter int DEBOUNCE_COUNT = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press_pulse
);
  localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
  logic          sync1_q, sync2_q, stable_q, pulse_q;
  logic [CW-1:0] cnt_q;
  // A level differing from the accepted one must persist for the full window before it flips
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q == stable_q) cnt_q <= '0;
      else if (cnt_q == CW'(DEBOUNCE_COUNT - 1)) begin
        cnt_q    <= '0;
        stable_q <= sync2_q;
        pulse_q  <= ~sync2_q;
      end else cnt_q <= cnt_q + CW'(1);
    end
  end
  assign press_pulse = pulse_q;
endmodule

// File: rtl/bake_countdown_timer.sv
// bake_countdown_timer: preset/preheat/countdown bake timer with BCD mm:ss outputs and alarm
module bake_countdown_timer
  import oven_pkg::*;
#(
  parameter int TICK_COUNT     = 50000000,
  parameter int DEBOUNCE_COUNT = 500000,
  parameter int DEFAULT_MIN    = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oven_en,
  input  logic             btn_up_n,
  input  logic             btn_dn_n,
  input  logic             btn_start_n,
  input  logic             heat_ready,
  output logic [BCD_W-1:0] m1,
  output logic [BCD_W-1:0] m0,
  output logic [BCD_W-1:0] s1,
  output logic [BCD_W-1:0] s0,
  output logic [2:0]       state_o,
  output logic             running,
  output logic             alarm
);
  localparam int TW = $clog2(TICK_COUNT + 1);
  localparam logic [7:0] PRESET_RST = {4'(DEFAULT_MIN / 10), 4'(DEFAULT_MIN % 10)};
  state_t        state_q, state_d;
  logic [7:0]    pre_q, pre_d;
  digits_t       dig_q, dig_d, dec;
  logic [TW-1:0] tick_q, tick_d;
  logic          up, dn, st, b0, b1, b2;
  btn_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_up (.clk(clk), .rst(rst), .btn_n(btn_up_n), .press_pulse(up));
  btn_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_dn (.clk(clk), .rst(rst), .btn_n(btn_dn_n), .press_pulse(dn));
  btn_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_st (.clk(clk), .rst(rst), .btn_n(btn_start_n), .press_pulse(st));
  assign b0 = dig_q.s0 == '0;
  assign b1 = b0 && dig_q.s1 == '0;
  assign b2 = b1 && dig_q.m0 == '0;
  assign dec.s0 = b0 ? BCD_MAX_U : dig_q.s0 - 4'd1;
  assign dec.s1 = !b0 ? dig_q.s1 : b1 ? BCD_MAX_T : dig_q.s1 - 4'd1;
  assign dec.m0 = !b1 ? dig_q.m0 : b2 ? BCD_MAX_U : dig_q.m0 - 4'd1;
  assign dec.m1 = b2 ? dig_q.m1 - 4'd1 : dig_q.m1;
  // Register state, preset, displayed digits and the one-second prescaler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= PRESET_RST;
      dig_q   <= show_min(PRESET_RST);
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      dig_q   <= dig_d;
      tick_q  <= tick_d;
    end
  end
  // Next state, preset edit, digit load/countdown; the prescaler only runs in BAKE
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    dig_d   = dig_q;
    tick_d  = '0;
    if (!oven_en) begin
      state_d = IDLE;
      dig_d   = show_min(pre_q);
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SET;
          dig_d   = show_min(pre_q);
        end
        SET: begin
          if (up && !dn && pre_q != PRESET_MAX)
            pre_d = pre_q[3:0] == BCD_MAX_U ? {pre_q[7:4] + 4'd1, 4'd0} : pre_q + 8'd1;
          else if (dn && !up && pre_q != PRESET_MIN)
            pre_d = pre_q[3:0] == 4'd0 ? {pre_q[7:4] - 4'd1, BCD_MAX_U} : pre_q - 8'd1;
          dig_d = show_min(pre_d);
          if (st) state_d = PREHEAT;
        end
        PREHEAT: begin
          dig_d = show_min(pre_q);
          if (heat_ready) state_d = BAKE;
        end
        BAKE: begin
          if (st) begin
            state_d = SET;
            dig_d   = show_min(pre_q);
          end else if (tick_q == TW'(TICK_COUNT - 1)) begin
            dig_d = dec;
            if (dec == '0) state_d = DONE;
          end else tick_d = tick_q + TW'(1);
        end
        DONE: begin
          dig_d = '0;
          if (st) begin
            state_d = SET;
            dig_d   = show_min(pre_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign m1      = dig_q.m1;
  assign m0      = dig_q.m0;
  assign s1      = dig_q.s1;
  assign s0      = dig_q.s0;
  assign state_o = state_q;
  assign running = state_q == BAKE;
  assign alarm   = state_q == DONE;
endmodule

// File: tb/tb_bake_countdown_timer.sv
// tb_bake_countdown_timer: directed scenario checks of the bake timer with short tick/debounce windows
module tb_bake_countdown_timer;
  logic       clk = 1'b0, rst, oven_en, btn_up_n, btn_dn_n, btn_start_n, heat_ready;
  logic [3:0] m1, m0, s1, s0;
  logic [2:0] state_o;
  logic       running, alarm;
  logic [15:0] dig;
  int n_cmp = 0, n_err = 0;

  assign dig = {m1, m0, s1, s0};

  bake_countdown_timer #(.TICK_COUNT(10), .DEBOUNCE_COUNT(4), .DEFAULT_MIN(30)) dut (
    .clk(clk), .rst(rst), .oven_en(oven_en), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
    .btn_start_n(btn_start_n), .heat_ready(heat_ready), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
    .state_o(state_o), .running(running), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic up, input logic dn, input logic st);
    btn_up_n = ~up; btn_dn_n = ~dn; btn_start_n = ~st;
    cyc(8);
    btn_up_n = 1'b1; btn_dn_n = 1'b1; btn_start_n = 1'b1;
    cyc(8);
  endtask

  task automatic test_reset;
    rst = 1'b1; oven_en = 1'b0; btn_up_n = 1'b1; btn_dn_n = 1'b1; btn_start_n = 1'b1; heat_ready = 1'b0;
    cyc(2);
    n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state_o); end
    n_cmp++; if (dig !== 16'h3000) begin n_err++; $display("FAIL reset_digits got %h want 3000", dig); end
    n_cmp++; if ({running, alarm} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {running, alarm}); end
    rst = 1'b0; oven_en = 1'b1;
    cyc(1);
    n_cmp++; if (state_o !== 3'd1) begin n_err++; $display("FAIL idle_to_set got %0d want 1", state_o); end
    n_cmp++; if (dig !== 16'h3000 || alarm !== 1'b0) begin n_err++; $display("FAIL set_digits got %h/%b want 3000/0", dig, alarm); end
  endtask

  task automatic test_debounce;
    btn_up_n = 1'b0;
    cyc(3);
    btn_up_n = 1'b1;
    cyc(12);
    n_cmp++; if (dig !== 16'h3000) begin n_err++; $display("FAIL glitch_ignored got %h want 3000", dig); end
    btn_up_n = 1'b0;
    cyc(6);
    n_cmp++; if (dig !== 16'h3000) begin n_err++; $display("FAIL press_early got %h want 3000", dig); end
    cyc(1);
    n_cmp++; if (dig !== 16'h3100) begin n_err++; $display("FAIL press_latency got %h want 3100", dig); end
    cyc(13);
    n_cmp++; if (dig !== 16'h3100) begin n_err++; $display("FAIL no_repeat got %h want 3100", dig); end
    btn_up_n = 1'b1;
    cyc(8);
  endtask

  task automatic test_saturation;
    repeat (68) press(1'b1, 1'b0, 1'b0);
    n_cmp++; if (dig !== 16'h9900) begin n_err++; $display("FAIL reach_99 got %h want 9900", dig); end
    press(1'b1, 1'b0, 1'b0);
    n_cmp++; if (dig !== 16'h9900) begin n_err++; $display("FAIL sat_99 got %h want 9900", dig); end
    press(1'b1, 1'b1, 1'b0);
    n_cmp++; if (dig !== 16'h9900) begin n_err++; $display("FAIL up_dn_same got %h want 9900", dig); end
    repeat (98) press(1'b0, 1'b1, 1'b0);
    n_cmp++; if (dig !== 16'h0100) begin n_err++; $display("FAIL reach_01 got %h want 0100", dig); end
    press(1'b0, 1'b1, 1'b0);
    n_cmp++; if (dig !== 16'h0100) begin n_err++; $display("FAIL sat_01 got %h want 0100", dig); end
  endtask

  task automatic test_bake;
    press(1'b0, 1'b0, 1'b1);
    cyc(50);
    n_cmp++; if (state_o !== 3'd2 || dig !== 16'h0100) begin n_err++; $display("FAIL preheat_hold got %0d/%h want 2/0100", state_o, dig); end
    heat_ready = 1'b1;
    cyc(1);
    n_cmp++; if (state_o !== 3'd3 || running !== 1'b1 || dig !== 16'h0100) begin n_err++; $display("FAIL bake_entry got %0d/%b/%h want 3/1/0100", state_o, running, dig); end
    cyc(9);
    n_cmp++; if (dig !== 16'h0100) begin n_err++; $display("FAIL before_tick got %h want 0100", dig); end
    cyc(1);
    n_cmp++; if (dig !== 16'h0059) begin n_err++; $display("FAIL first_tick got %h want 0059", dig); end
    cyc(589);
    n_cmp++; if (state_o !== 3'd3 || dig !== 16'h0001) begin n_err++; $display("FAIL last_second got %0d/%h want 3/0001", state_o, dig); end
    cyc(1);
    n_cmp++; if (state_o !== 3'd4 || dig !== 16'h0000 || alarm !== 1'b1 || running !== 1'b0) begin n_err++; $display("FAIL done got %0d/%h/%b/%b want 4/0000/1/0", state_o, dig, alarm, running); end
    press(1'b0, 1'b0, 1'b1);
    n_cmp++; if (state_o !== 3'd1 || dig !== 16'h0100 || alarm !== 1'b0) begin n_err++; $display("FAIL ack got %0d/%h/%b want 1/0100/0", state_o, dig, alarm); end
  endtask

  task automatic test_abort;
    repeat (9) press(1'b1, 1'b0, 1'b0);
    n_cmp++; if (dig !== 16'h1000) begin n_err++; $display("FAIL preset_10 got %h want 1000", dig); end
    btn_start_n = 1'b0;
    cyc(7);
    n_cmp++; if (state_o !== 3'd2) begin n_err++; $display("FAIL min_dwell got %0d want 2", state_o); end
    cyc(1);
    n_cmp++; if (state_o !== 3'd3) begin n_err++; $display("FAIL bake_after_dwell got %0d want 3", state_o); end
    btn_start_n = 1'b1;
    cyc(100);
    n_cmp++; if (dig !== 16'h0950) begin n_err++; $display("FAIL ten_ticks got %h want 0950", dig); end
    btn_start_n = 1'b0;
    cyc(7);
    n_cmp++; if (state_o !== 3'd1 || dig !== 16'h1000) begin n_err++; $display("FAIL abort got %0d/%h want 1/1000", state_o, dig); end
    btn_start_n = 1'b1;
    cyc(8);
  endtask

  task automatic test_idle_reset;
    btn_start_n = 1'b0;
    cyc(8);
    btn_start_n = 1'b1;
    cyc(20);
    n_cmp++; if (state_o !== 3'd3) begin n_err++; $display("FAIL midbake got %0d want 3", state_o); end
    oven_en = 1'b0;
    cyc(1);
    n_cmp++; if (state_o !== 3'd0 || running !== 1'b0 || dig !== 16'h1000) begin n_err++; $display("FAIL oven_off got %0d/%b/%h want 0/0/1000", state_o, running, dig); end
    oven_en = 1'b1;
    cyc(1);
    n_cmp++; if (state_o !== 3'd1) begin n_err++; $display("FAIL oven_on got %0d want 1", state_o); end
    repeat (9) press(1'b0, 1'b1, 1'b0);
    btn_start_n = 1'b0;
    cyc(8);
    btn_start_n = 1'b1;
    cyc(600);
    n_cmp++; if (state_o !== 3'd4 || alarm !== 1'b1) begin n_err++; $display("FAIL done_again got %0d/%b want 4/1", state_o, alarm); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (alarm !== 1'b0 || state_o !== 3'd0) begin n_err++; $display("FAIL async_rst got %b/%0d want 0/0", alarm, state_o); end
    n_cmp++; if (dig !== 16'h3000) begin n_err++; $display("FAIL async_rst_digits got %h want 3000", dig); end
    @(negedge clk);
    rst = 1'b0;
    cyc(2);
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_saturation();
    test_bake();
    test_abort();
    test_idle_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
